// File: rtl/ringosc_freq_meter_if.sv
// Bus bundle for ringosc_freq_meter: asynchronous reference/start inputs,
// window configuration, byte readout select and the measurement results.
interface ringosc_freq_meter_if #(
  parameter int COUNT_WIDTH = 24,
  parameter int GATE_W      = 4
);
  logic                   ref_in;
  logic                   start_in;
  logic [GATE_W-1:0]      gate_n;
  logic [1:0]             byte_sel;
  logic                   busy;
  logic                   valid;
  logic                   overflow;
  logic                   result_stb;
  logic [COUNT_WIDTH-1:0] result;
  logic [7:0]             byte_out;

  modport master (
    output ref_in, start_in, gate_n, byte_sel,
    input  busy, valid, overflow, result_stb, result, byte_out
  );

  modport slave (
    input  ref_in, start_in, gate_n, byte_sel,
    output busy, valid, overflow, result_stb, result, byte_out
  );
endinterface

// File: rtl/ringosc_freq_meter.sv
// ringosc_freq_meter: gated-window frequency meter clocked by the divided ring
// output. Counts dff_q_clk cycles over gate_n+1 periods of an asynchronous
// reference and exposes the latched count bytewise.
// Optional feature macro RINGOSC_FMETER_CONTINUOUS_EN: back-to-back windows
// while the synchronised start level stays high (single-shot when undefined).
module ringosc_freq_meter #(
  parameter int COUNT_WIDTH = 24,
  parameter int GATE_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                 dff_q_clk,
  input logic                 rst_n,
  ringosc_freq_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t                 state_r, state_s;
  logic [SYNC_STAGES-1:0] ref_sync_r, start_sync_r;
  logic                   ref_d_r, start_d_r;
  logic                   ref_rise_s, start_rise_s, start_lvl_s;
  logic [GATE_W-1:0]      gate_r, per_cnt_r;
  logic [COUNT_WIDTH-1:0] cnt_r, cnt_inc_s, result_r;
  logic                   sat_r, sat_s, latch_s;
  logic                   busy_r, valid_r, overflow_r, stb_r;
  logic [31:0]            res_ext_s;
  logic [7:0]             byte_s;

  // Synchronise the asynchronous inputs and keep one delayed copy for edge detection
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sync_r   <= '0;
      start_sync_r <= '0;
      ref_d_r      <= 1'b0;
      start_d_r    <= 1'b0;
    end else begin
      ref_sync_r   <= {ref_sync_r[SYNC_STAGES-2:0], bus.ref_in};
      start_sync_r <= {start_sync_r[SYNC_STAGES-2:0], bus.start_in};
      ref_d_r      <= ref_sync_r[SYNC_STAGES-1];
      start_d_r    <= start_sync_r[SYNC_STAGES-1];
    end
  end

  // Edge strobes, saturating increment and window-close detection
  always_comb begin
    start_lvl_s  = start_sync_r[SYNC_STAGES-1];
    ref_rise_s   = ref_sync_r[SYNC_STAGES-1] & ~ref_d_r;
    start_rise_s = start_lvl_s & ~start_d_r;
    sat_s        = (cnt_r == CNT_MAX);
    if (sat_s) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + COUNT_WIDTH'(1);
    end
    latch_s = (state_r == COUNT) && (state_s == DONE);
  end

  // Next-state logic; a window closes on the ref edge that completes gate_n+1 periods
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_rise_s) begin
          state_s = ARM;
        end else begin
          state_s = IDLE;
        end
      end
      ARM: begin
`ifdef RINGOSC_FMETER_CONTINUOUS_EN
        if (!start_lvl_s) begin
          state_s = IDLE;
        end else if (ref_rise_s) begin
          state_s = COUNT;
        end else begin
          state_s = ARM;
        end
`else
        if (ref_rise_s) begin
          state_s = COUNT;
        end else begin
          state_s = ARM;
        end
`endif
      end
      COUNT: begin
`ifdef RINGOSC_FMETER_CONTINUOUS_EN
        if (!start_lvl_s) begin
          state_s = IDLE;
        end else if (ref_rise_s && (per_cnt_r == gate_r)) begin
          state_s = DONE;
        end else begin
          state_s = COUNT;
        end
`else
        if (ref_rise_s && (per_cnt_r == gate_r)) begin
          state_s = DONE;
        end else begin
          state_s = COUNT;
        end
`endif
      end
      DONE: begin
`ifdef RINGOSC_FMETER_CONTINUOUS_EN
        if (!start_lvl_s) begin
          state_s = IDLE;
        end else begin
          state_s = COUNT;
        end
`else
        state_s = IDLE;
`endif
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters and result registers; result is latched on the closing edge so it
  // changes together with result_stb, and the counter restarts for the next window
  always_ff @(posedge dff_q_clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_r     <= '0;
      per_cnt_r  <= '0;
      cnt_r      <= '0;
      sat_r      <= 1'b0;
      result_r   <= '0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      stb_r      <= 1'b0;
    end else begin
      busy_r <= (state_s == ARM) || (state_s == COUNT);
      stb_r  <= latch_s;
      case (state_r)
        IDLE: begin
          if (start_rise_s) begin
            gate_r     <= bus.gate_n;
            cnt_r      <= '0;
            per_cnt_r  <= '0;
            sat_r      <= 1'b0;
            overflow_r <= 1'b0;
            valid_r    <= 1'b0;
          end
        end
        ARM: begin
          if (ref_rise_s) begin
            cnt_r     <= '0;
            per_cnt_r <= '0;
          end
        end
        COUNT: begin
          if (latch_s) begin
            result_r   <= cnt_inc_s;
            overflow_r <= sat_r | sat_s;
            valid_r    <= 1'b1;
            cnt_r      <= '0;
            per_cnt_r  <= '0;
            sat_r      <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
            if (sat_s) begin
              sat_r <= 1'b1;
            end
            if (ref_rise_s) begin
              per_cnt_r <= per_cnt_r + GATE_W'(1);
            end
          end
        end
        DONE: begin
          // The DONE edge already belongs to the next window in continuous mode
          cnt_r <= cnt_inc_s;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  // Byte readout: zero-extend the result to 32 bits and pick the selected byte
  always_comb begin
    res_ext_s = 32'd0;
    res_ext_s[COUNT_WIDTH-1:0] = result_r;
    byte_s = res_ext_s[{bus.byte_sel, 3'b000} +: 8];
  end

  assign bus.busy       = busy_r;
  assign bus.valid      = valid_r;
  assign bus.overflow   = overflow_r;
  assign bus.result_stb = stb_r;
  assign bus.result     = result_r;
  assign bus.byte_out   = byte_s;

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Directed self-checking bench for ringosc_freq_meter. Two instances share the
// stimulus: a 24-bit counter and a 9-bit counter for the saturation case.
module tb_ringosc_freq_meter;

  localparam int CW_A = 24;
  localparam int CW_B = 9;
  localparam int GW   = 4;
  localparam int SS   = 2;

  logic          clk       = 1'b0;
  logic          clk_en    = 1'b0;
  logic          rst_n     = 1'b1;
  logic          ref_lvl   = 1'b0;
  logic          start_lvl = 1'b0;
  logic [GW-1:0] gate_v    = '0;
  logic [1:0]    sel_v     = '0;
  int            ref_period = 0;
  int            checks = 0;
  int            fails  = 0;
  int            stb_a  = 0;

  ringosc_freq_meter_if #(.COUNT_WIDTH(CW_A), .GATE_W(GW)) ifa ();
  ringosc_freq_meter_if #(.COUNT_WIDTH(CW_B), .GATE_W(GW)) ifb ();

  assign ifa.ref_in   = ref_lvl;
  assign ifa.start_in = start_lvl;
  assign ifa.gate_n   = gate_v;
  assign ifa.byte_sel = sel_v;
  assign ifb.ref_in   = ref_lvl;
  assign ifb.start_in = start_lvl;
  assign ifb.gate_n   = gate_v;
  assign ifb.byte_sel = sel_v;

  ringosc_freq_meter #(.COUNT_WIDTH(CW_A), .GATE_W(GW), .SYNC_STAGES(SS)) dut_a (
    .dff_q_clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  ringosc_freq_meter #(.COUNT_WIDTH(CW_B), .GATE_W(GW), .SYNC_STAGES(SS)) dut_b (
    .dff_q_clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  // Gated clock so reset can be applied with the clock stopped
  always #5 if (clk_en) clk = ~clk;

  // Count result strobes of the wide instance
  always @(negedge clk) begin
    if (ifa.result_stb === 1'b1) stb_a <= stb_a + 1;
  end

  // Reference generator: rising edge every ref_period clock cycles
  initial begin
    forever begin
      if (ref_period == 0) begin
        ref_lvl = 1'b0;
        @(negedge clk);
      end else begin
        ref_lvl = 1'b1;
        repeat (ref_period / 2) @(negedge clk);
        ref_lvl = 1'b0;
        repeat (ref_period - ref_period / 2) @(negedge clk);
      end
    end
  end

  task automatic set_period(input int p);
    int prev;
    prev = ref_period;
    ref_period = p;
    repeat (prev + p + 4) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_lvl = 1'b1;
    repeat (6) @(negedge clk);
    start_lvl = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifa.valid === 1'b1 && ifa.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    bit seen_busy;
    #3 rst_n = 1'b0;
    #10;
    checks++; if (ifa.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
    checks++; if (ifa.valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", ifa.valid); end
    checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL rst_overflow: got %b want 0", ifa.overflow); end
    checks++; if (ifa.result_stb !== 1'b0) begin fails++; $display("FAIL rst_stb: got %b want 0", ifa.result_stb); end
    checks++; if (ifa.result !== 24'd0) begin fails++; $display("FAIL rst_result: got %0d want 0", ifa.result); end
    checks++; if (ifa.byte_out !== 8'd0) begin fails++; $display("FAIL rst_byte: got %0d want 0", ifa.byte_out); end
    checks++; if (ifb.result !== 9'd0) begin fails++; $display("FAIL rst_result_b: got %0d want 0", ifb.result); end
    rst_n  = 1'b1;
    #2 clk_en = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ifa.busy !== 1'b0) seen_busy = 1'b1;
    end
    checks++; if (seen_busy) begin fails++; $display("FAIL idle_busy: got 1 want 0"); end
  endtask

  task automatic test_single_100();
    bit ok;
    int s0;
    set_period(100);
    gate_v = 4'd0;
    s0 = stb_a;
    pulse_start();
    wait_done(1000, ok);
    repeat (20) @(negedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL p100_done: got timeout want done"); end
    checks++; if (ifa.result !== 24'd100) begin fails++; $display("FAIL p100_result: got %0d want 100", ifa.result); end
    checks++; if (ifa.valid !== 1'b1) begin fails++; $display("FAIL p100_valid: got %b want 1", ifa.valid); end
    checks++; if (ifa.overflow !== 1'b0) begin fails++; $display("FAIL p100_overflow: got %b want 0", ifa.overflow); end
    checks++; if (stb_a - s0 != 1) begin fails++; $display("FAIL p100_stb_count: got %0d want 1", stb_a - s0); end
  endtask

  task automatic test_bytes_592();
    bit ok;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h50; exp_b[1] = 8'h02; exp_b[2] = 8'h00; exp_b[3] = 8'h00;
    set_period(37);
    gate_v = 4'd15;
    pulse_start();
    wait_done(2000, ok);
    checks++; if (ifa.result !== 24'd592) begin fails++; $display("FAIL p37_result: got %0d want 592", ifa.result); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      sel_v = b[1:0];
      #1;
      checks++;
      if (ifa.byte_out !== exp_b[b]) begin
        fails++; $display("FAIL byte_sel%0d: got %h want %h", b, ifa.byte_out, exp_b[b]);
      end
    end
    sel_v = 2'd0;
  endtask

  task automatic test_overflow();
    bit ok;
    set_period(600);
    gate_v = 4'd0;
    pulse_start();
    wait_done(3000, ok);
    checks++; if (ifb.result !== 9'd511) begin fails++; $display("FAIL sat_result: got %0d want 511", ifb.result); end
    checks++; if (ifb.overflow !== 1'b1) begin fails++; $display("FAIL sat_overflow: got %b want 1", ifb.overflow); end
    checks++; if (ifa.result !== 24'd600) begin fails++; $display("FAIL wide_600: got %0d want 600", ifa.result); end
    set_period(10);
    pulse_start();
    wait_done(500, ok);
    checks++; if (ifb.result !== 9'd10) begin fails++; $display("FAIL p10_result: got %0d want 10", ifb.result); end
    checks++; if (ifb.overflow !== 1'b0) begin fails++; $display("FAIL p10_overflow: got %b want 0", ifb.overflow); end
    checks++; if (ifb.valid !== 1'b1) begin fails++; $display("FAIL p10_valid: got %b want 1", ifb.valid); end
  endtask

  task automatic test_abort_and_retoggle();
    bit ok;
    int s0;
    set_period(100);
    gate_v = 4'd3;
    pulse_start();
    repeat (150) @(negedge clk);
    checks++; if (ifa.busy !== 1'b1) begin fails++; $display("FAIL abort_pre_busy: got %b want 1", ifa.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ifa.busy, ifa.valid, ifa.overflow, ifa.result_stb} !== 4'b0000 || ifa.result !== 24'd0) begin
      fails++; $display("FAIL abort_outputs: got busy=%b valid=%b ovf=%b stb=%b result=%0d want all 0",
                        ifa.busy, ifa.valid, ifa.overflow, ifa.result_stb, ifa.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    s0 = stb_a;
    pulse_start();
    repeat (100) @(negedge clk);
    gate_v = 4'd0;
    pulse_start();
    wait_done(2000, ok);
    checks++; if (!ok) begin fails++; $display("FAIL retoggle_done: got timeout want done"); end
    checks++; if (ifa.result !== 24'd400) begin fails++; $display("FAIL retoggle_result: got %0d want 400", ifa.result); end
    checks++; if (stb_a - s0 != 1) begin fails++; $display("FAIL retoggle_stb_count: got %0d want 1", stb_a - s0); end
  endtask

`ifdef RINGOSC_FMETER_CONTINUOUS_EN
  task automatic test_continuous();
    bit ok;
    int gap;
    set_period(50);
    gate_v = 4'd1;
    @(negedge clk);
    start_lvl = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (ifa.result_stb === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin fails++; $display("FAIL cont_first_stb: got timeout want strobe"); end
    checks++; if (ifa.result !== 24'd100) begin fails++; $display("FAIL cont_first_result: got %0d want 100", ifa.result); end
    for (int w = 0; w < 3; w++) begin
      gap = 0;
      ok  = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        gap++;
        if (ifa.result_stb === 1'b1) begin ok = 1'b1; break; end
      end
      checks++; if (!ok || gap != 100) begin fails++; $display("FAIL cont_gap%0d: got %0d want 100", w, gap); end
      checks++; if (ifa.result !== 24'd100) begin fails++; $display("FAIL cont_result%0d: got %0d want 100", w, ifa.result); end
      checks++; if (ifa.valid !== 1'b1) begin fails++; $display("FAIL cont_valid%0d: got %b want 1", w, ifa.valid); end
    end
    repeat (10) @(negedge clk);
    start_lvl = 1'b0;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gap++;
      if (ifa.busy === 1'b0) break;
    end
    checks++; if (gap > SS + 2) begin fails++; $display("FAIL cont_stop: got %0d cycles want <= %0d", gap, SS + 2); end
    repeat (200) @(negedge clk);
    checks++; if (ifa.busy !== 1'b0) begin fails++; $display("FAIL cont_idle: got busy %b want 0", ifa.busy); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef RINGOSC_FMETER_CONTINUOUS_EN
    test_continuous();
`else
    test_single_100();
    test_bytes_592();
    test_overflow();
    test_abort_and_retoggle();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
